// File: rtl/i2c_master_fsm.sv
// Single-byte I2C bus master: START, address + R/W, slave ACK, one data byte, ACK/NACK, STOP.
// SCL is derived from clk; every bus slot is four quarters of CLK_DIV clocks each.
module i2c_master_fsm #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ZERO = DW'(32'd0);
  localparam logic [DW-1:0] DIV_ONE  = DW'(32'd1);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_ADDR  = 4'd2,
    ST_AACK  = 4'd3,
    ST_WRITE = 4'd4,
    ST_WACK  = 4'd5,
    ST_READ  = 4'd6,
    ST_MNACK = 4'd7,
    ST_STOP  = 4'd8
  } state_e;

  state_e        state_r;
  state_e        state_nx_s;
  logic [DW-1:0] div_r;
  logic [DW-1:0] div_nx_s;
  logic [1:0]    q_r;
  logic [1:0]    q_nx_s;
  logic [2:0]    slot_r;
  logic [2:0]    slot_nx_s;
  logic [7:0]    frame_r;
  logic [7:0]    wdata_r;
  logic [7:0]    rdata_r;
  logic          sample_r;
  logic          busy_r;
  logic          done_r;
  logic          ack_err_r;
  logic          scl_r;
  logic          sda_low_r;
  logic          tick_s;
  logic          accept_s;
  logic          sda_in_s;
  logic          tx_bit_s;
  logic [1:0]    drive_s;

  // Byte states step the slot counter 0..7; single-slot states keep it at zero.
  function automatic logic is_byte_state(input state_e st);
    logic res;
    case (st)
      ST_ADDR, ST_WRITE, ST_READ: res = 1'b1;
      default:                    res = 1'b0;
    endcase
    return res;
  endfunction

  // Bus levels for a given position, returned as {scl, sda_pull_low}.
  function automatic logic [1:0] bus_drive(input state_e st, input logic [1:0] q, input logic tx_bit);
    logic [1:0] d;
    case (st)
      ST_IDLE:                             d = 2'b10;
      ST_START:                            d = {1'b1, q[1]};
      ST_ADDR, ST_WRITE:                   d = {q[1], ~tx_bit};
      ST_AACK, ST_WACK, ST_READ, ST_MNACK: d = {q[1], 1'b0};
      ST_STOP:                             d = {(q != 2'd0), ~q[1]};
      default:                             d = 2'b10;
    endcase
    return d;
  endfunction

  assign sda      = sda_low_r ? 1'b0 : 1'bz;
  assign sda_in_s = sda;
  assign tick_s   = (state_r != ST_IDLE) && (div_r == DIV_LAST);
  assign tx_bit_s = (state_nx_s == ST_WRITE) ? wdata_r[3'd7 - slot_nx_s] : frame_r[3'd7 - slot_nx_s];
  assign drive_s  = bus_drive(state_nx_s, q_nx_s, tx_bit_s);

  // Next bus position: clock divider, quarter, slot and protocol state.
  always_comb begin
    state_nx_s = state_r;
    div_nx_s   = div_r;
    q_nx_s     = q_r;
    slot_nx_s  = slot_r;
    accept_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      div_nx_s  = DIV_ZERO;
      q_nx_s    = 2'd0;
      slot_nx_s = 3'd0;
      if (start) begin
        accept_s   = 1'b1;
        state_nx_s = ST_START;
      end else begin
        state_nx_s = ST_IDLE;
      end
    end else if (!tick_s) begin
      div_nx_s = div_r + DIV_ONE;
    end else begin
      div_nx_s = DIV_ZERO;
      q_nx_s   = q_r + 2'd1;
      if (q_r == 2'd3) begin
        slot_nx_s = is_byte_state(state_r) ? (slot_r + 3'd1) : 3'd0;
        case (state_r)
          ST_START: state_nx_s = ST_ADDR;
          ST_ADDR:  state_nx_s = (slot_r == 3'd7) ? ST_AACK : ST_ADDR;
          ST_AACK: begin
            if (sample_r) begin
              state_nx_s = ST_STOP;
            end else if (frame_r[0]) begin
              state_nx_s = ST_READ;
            end else begin
              state_nx_s = ST_WRITE;
            end
          end
          ST_WRITE: state_nx_s = (slot_r == 3'd7) ? ST_WACK : ST_WRITE;
          ST_WACK:  state_nx_s = ST_STOP;
          ST_READ:  state_nx_s = (slot_r == 3'd7) ? ST_MNACK : ST_READ;
          ST_MNACK: state_nx_s = ST_STOP;
          ST_STOP:  state_nx_s = ST_IDLE;
          default:  state_nx_s = ST_IDLE;
        endcase
      end else begin
        slot_nx_s = slot_r;
      end
    end
  end

  // Transaction state, captured data and registered bus/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      div_r     <= DIV_ZERO;
      q_r       <= 2'd0;
      slot_r    <= 3'd0;
      frame_r   <= 8'h00;
      wdata_r   <= 8'h00;
      rdata_r   <= 8'h00;
      sample_r  <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      scl_r     <= 1'b1;
      sda_low_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      div_r     <= div_nx_s;
      q_r       <= q_nx_s;
      slot_r    <= slot_nx_s;
      scl_r     <= drive_s[1];
      sda_low_r <= drive_s[0];
      done_r    <= 1'b0;
      if (accept_s) begin
        frame_r   <= {addr, rw};
        wdata_r   <= wdata;
        ack_err_r <= 1'b0;
        busy_r    <= 1'b1;
      end else if (tick_s && (q_r == 2'd3) && (state_r == ST_STOP)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else if (tick_s && (q_r == 2'd3) && (state_r == ST_AACK) && sample_r) begin
        ack_err_r <= 1'b1;
      end
      // SDA is sampled in the middle of the SCL-high half of the slot.
      if (tick_s && (q_r == 2'd2)) begin
        sample_r <= sda_in_s;
        if (state_r == ST_READ) begin
          rdata_r <= {rdata_r[6:0], sda_in_s};
        end
      end
    end
  end

  assign rdata   = rdata_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign ack_err = ack_err_r;
  assign scl     = scl_r;

  i2c_master_fsm_checker u_checker (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy_r),
    .done    (done_r),
    .ack_err (ack_err_r),
    .scl     (scl_r)
  );

endmodule

// Status and bus-clock relationships of the master that must hold every cycle.
module i2c_master_fsm_checker (
  input logic clk,
  input logic rst,
  input logic busy,
  input logic done,
  input logic ack_err,
  input logic scl
);

  a_done_not_busy: assert property (@(posedge clk) disable iff (rst) done |-> !busy);
  a_done_after_busy: assert property (@(posedge clk) disable iff (rst) done |-> $past(busy));
  a_scl_low_busy: assert property (@(posedge clk) disable iff (rst) !scl |-> busy);
  a_err_while_busy: assert property (@(posedge clk) disable iff (rst) $rose(ack_err) |-> busy);

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Directed bench for i2c_master_fsm: table of transactions against a bit-level slave model,
// plus hand-written reset-mid-transaction and start-while-busy sequences.
module tb_i2c_master_fsm;

  localparam int DIV = 4;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       present;
    logic [7:0] sdata;
    int         poke;
    int         exp_cyc;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       scl;
  wire        sda_w;

  logic       sl_low = 1'b0;
  logic       sl_clr;
  logic       sl_present;
  logic [7:0] sl_rdata;
  logic [7:0] sl_addr;
  logic [7:0] sl_data;
  logic       sl_mnack;
  int         sl_cnt;

  logic       mon_clr;
  logic       p_scl;
  logic       p_sda;
  int         falls;
  int         rises;

  int checks = 0;
  int errors = 0;
  vec_t vecs [7];
  vec_t fin;

  always #5 clk = ~clk;

  pullup (sda_w);
  assign sda_w = sl_low ? 1'b0 : 1'bz;

  i2c_master_fsm #(.CLK_DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl     (scl),
    .sda     (sda_w)
  );

  // Slave: counts SCL rising edges, captures address/data, ACKs and returns read data.
  always @(posedge scl or negedge scl or posedge sl_clr) begin
    if (sl_clr) begin
      sl_cnt   <= 0;
      sl_addr  <= 8'h00;
      sl_data  <= 8'h00;
      sl_mnack <= 1'b0;
      sl_low   <= 1'b0;
    end else if (scl) begin
      sl_cnt <= sl_cnt + 1;
      if (sl_cnt < 8) sl_addr <= {sl_addr[6:0], sda_w};
      else if (sl_cnt >= 9 && sl_cnt <= 16) sl_data <= {sl_data[6:0], sda_w};
      else if (sl_cnt == 17) sl_mnack <= sda_w;
    end else begin
      if (sl_cnt == 8) sl_low <= sl_present;
      else if (sl_cnt >= 9 && sl_cnt <= 16 && sl_present && sl_addr[0]) sl_low <= ~sl_rdata[16 - sl_cnt];
      else if (sl_cnt == 17 && sl_present && !sl_addr[0]) sl_low <= 1'b1;
      else sl_low <= 1'b0;
    end
  end

  // Bus monitor: SDA edges seen while SCL stays high (START fall, STOP rise).
  always @(negedge clk) begin
    if (mon_clr) begin
      falls <= 0;
      rises <= 0;
    end else if (scl && p_scl && (sda_w != p_sda)) begin
      if (sda_w) rises <= rises + 1;
      else falls <= falls + 1;
    end
    p_scl <= scl;
    p_sda <= sda_w;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic prep_slave(input logic present, input logic [7:0] sdata);
    @(negedge clk);
    sl_present = present;
    sl_rdata   = sdata;
    sl_clr     = 1'b1;
    mon_clr    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sl_clr  = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   cyc;
    logic seen;
    logic idle_ok;
    prep_slave(v.present, v.sdata);
    addr  = v.addr;
    rw    = v.rw;
    wdata = v.wdata;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
      end else if (cyc == v.poke) begin
        start = 1'b1;
        addr  = ~v.addr;
        rw    = ~v.rw;
        wdata = ~v.wdata;
      end else begin
        start = 1'b0;
        addr  = v.addr;
        rw    = v.rw;
        wdata = v.wdata;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(v.exp_cyc));
    check({tag, "_ack_err"}, 32'(ack_err), 32'(v.exp_err));
    check({tag, "_rdata"}, 32'(rdata), 32'(v.exp_rdata));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    idle_ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (busy || done || !scl || (sda_w !== 1'b1)) idle_ok = 1'b0;
    end
    check({tag, "_idle_bus"}, 32'(idle_ok), 32'd1);
    check({tag, "_addr_byte"}, 32'(sl_addr), 32'({v.addr, v.rw}));
    if (v.present && !v.rw) check({tag, "_wdata"}, 32'(sl_data), 32'(v.wdata));
    if (v.present && v.rw) check({tag, "_mnack"}, 32'(sl_mnack), 32'd1);
    check({tag, "_start_cond"}, 32'(falls), 32'd1);
    check({tag, "_stop_cond"}, 32'(rises), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic no_done;
    rst        = 1'b1;
    start      = 1'b0;
    addr       = 7'h00;
    rw         = 1'b0;
    wdata      = 8'h00;
    sl_clr     = 1'b1;
    sl_present = 1'b0;
    sl_rdata   = 8'h00;
    mon_clr    = 1'b1;

    vecs[0] = '{7'h54, 1'b0, 8'hA8, 1'b1, 8'h00, -1, 320, 1'b0, 8'h00};
    vecs[1] = '{7'h54, 1'b1, 8'h00, 1'b1, 8'h3C, -1, 320, 1'b0, 8'h3C};
    vecs[2] = '{7'h1A, 1'b0, 8'h55, 1'b0, 8'h00, -1, 176, 1'b1, 8'h3C};
    vecs[3] = '{7'h3A, 1'b0, 8'hC3, 1'b1, 8'h00, 100, 320, 1'b0, 8'h3C};
    vecs[4] = '{7'h01, 1'b1, 8'h00, 1'b1, 8'hA5, -1, 320, 1'b0, 8'hA5};
    vecs[5] = '{7'h22, 1'b1, 8'h00, 1'b0, 8'h00, -1, 176, 1'b1, 8'hA5};
    vecs[6] = '{7'h00, 1'b0, 8'hFF, 1'b1, 8'h00, 150, 320, 1'b0, 8'hA5};
    fin     = '{7'h2B, 1'b1, 8'h00, 1'b1, 8'h5A, -1, 320, 1'b0, 8'h5A};

    repeat (3) @(negedge clk);
    check("reset_scl", 32'(scl), 32'd1);
    check("reset_sda", 32'(sda_w), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ack_err", 32'(ack_err), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], $sformatf("v%0d", i));
    end

    // Reset in the middle of the 4th WRITE bit (slot 13, quarter 1: SCL low, data bit 0 driven).
    prep_slave(1'b1, 8'h00);
    addr  = 7'h33;
    rw    = 1'b0;
    wdata = 8'h81;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (214) @(negedge clk);
    check("mid_pre_sda", 32'(sda_w), 32'd0);
    check("mid_pre_scl", 32'(scl), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_scl", 32'(scl), 32'd1);
    check("mid_rst_sda", 32'(sda_w), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    check("mid_rst_no_done", 32'(no_done), 32'd1);
    run_txn(fin, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
